// File: rtl/ext_bus_responder.sv
// ext_bus_responder
//
// Peripheral-side responder for the CPU's 8-bit external bus bridge. Each
// bridge transfer is decoded against a small register file (ID, VERSION,
// CTRL, STATUS, IRQ_PEND, IRQ_MASK, TIMER_LO/HI) and 16 bytes of scratch
// storage. The responder then returns a one-cycle acknowledge, with read data
// on reads.
//
// Ports:
//   clk_clk      in   1  single clock
//   reset_reset  in   1  synchronous, active-high reset
//   bus_enable   in   1  transfer request, held by the bridge until acknowledged
//   rw           in   1  1 = read, 0 = write
//   address      in   8  register address
//   byte_enable  in   1  write qualifier (ignored on reads)
//   write_data   in   8  write data
//   read_data    out  8  read data, non-zero only while acknowledge = 1
//   acknowledge  out  1  one-cycle completion pulse
//   irq          out  1  registered |(IRQ_PEND & IRQ_MASK)
//   ctrl_out     out  8  CTRL register contents
//   status_in    in   8  status bits, 2-flop synchronised
//   irq_src      in   8  interrupt sources, rising-edge detected
module ext_bus_responder #(
    parameter logic [7:0]  ID_VALUE  = 8'hA8,
    parameter logic [7:0]  VERSION   = 8'h01,
    parameter int unsigned ACK_DELAY = 0
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       bus_enable,
    input  logic       rw,
    input  logic [7:0] address,
    input  logic       byte_enable,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    output logic       acknowledge,
    output logic       irq,
    output logic [7:0] ctrl_out,
    input  logic [7:0] status_in,
    input  logic [7:0] irq_src
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Last wait-counter value before moving on to ACK (unused when ACK_DELAY = 0).
    localparam logic [3:0] DELAY_LAST = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        be_q, be_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;
    logic [7:0]  src_prev_q, src_prev_d;
    logic [7:0]  scratch_q [16];
    logic [7:0]  scratch_d [16];

    logic        commit_wr_s;
    logic        lo_read_s;
    logic [7:0]  clr_s;

    assign read_data   = rdata_q;
    assign acknowledge = ack_q;
    assign irq         = irq_q;
    assign ctrl_out    = ctrl_q;

    // Transfer FSM: latch the request in IDLE, optionally wait, acknowledge, then
    // hold in RECOVER until the bridge drops bus_enable so a held request is not
    // serviced twice.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    addr_d     = address;
                    rw_d       = rw;
                    be_d       = byte_enable;
                    wdata_d    = write_data;
                    wait_cnt_d = 4'd0;
                    if (ACK_DELAY > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == DELAY_LAST) begin
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (!bus_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write commit and TIMER_LO side effect, both taking effect after the ACK cycle.
    always_comb begin
        commit_wr_s = (state_q == ST_ACK) && !rw_q && be_q;
        lo_read_s   = (state_q == ST_ACK) && rw_q && (addr_q == 8'h06);
        ctrl_d      = ctrl_q;
        mask_d      = mask_q;
        clr_s       = 8'h00;
        scratch_d   = scratch_q;
        if (commit_wr_s) begin
            if (addr_q[7:4] == 4'h1) begin
                // Scratch has no reset, so a write aborted by reset must be dropped here.
                if (!reset_reset) begin
                    scratch_d[addr_q[3:0]] = wdata_q;
                end else begin
                    scratch_d = scratch_q;
                end
            end else begin
                case (addr_q)
                    8'h02:   ctrl_d = wdata_q;
                    8'h04:   clr_s  = wdata_q;
                    8'h05:   mask_d = wdata_q;
                    default: ctrl_d = ctrl_q;
                endcase
            end
        end else begin
            ctrl_d = ctrl_q;
        end
        if (lo_read_s) begin
            shadow_d = timer_q[15:8];
        end else begin
            shadow_d = shadow_q;
        end
        // A new edge wins over a simultaneous write-1-to-clear on the same bit.
        pend_d = (pend_q & ~clr_s) | (irq_src & ~src_prev_q);
    end

    // Free-running timer, synchronisers, edge history and registered irq/ack.
    always_comb begin
        timer_d    = timer_q + 16'd1;
        sync1_d    = status_in;
        sync2_d    = sync1_q;
        src_prev_d = irq_src;
        irq_d      = |(pend_q & mask_q);
        ack_d      = (state_d == ST_ACK);
    end

    // Read mux, registered on entry to ACK. The *_d values are used where a
    // register may change on that same edge, so read_data matches what the
    // register holds during the ACK cycle itself.
    always_comb begin
        rdata_d = 8'h00;
        if ((state_d == ST_ACK) && rw_d) begin
            if (addr_d[7:4] == 4'h1) begin
                rdata_d = scratch_q[addr_d[3:0]];
            end else begin
                case (addr_d)
                    8'h00:   rdata_d = ID_VALUE;
                    8'h01:   rdata_d = VERSION;
                    8'h02:   rdata_d = ctrl_q;
                    8'h03:   rdata_d = sync2_d;
                    8'h04:   rdata_d = pend_d;
                    8'h05:   rdata_d = mask_q;
                    8'h06:   rdata_d = timer_d[7:0];
                    8'h07:   rdata_d = shadow_q;
                    default: rdata_d = 8'h00;
                endcase
            end
        end else begin
            rdata_d = 8'h00;
        end
    end

    // State, transfer latches and register file with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 8'h00;
            rw_q       <= 1'b0;
            be_q       <= 1'b0;
            wdata_q    <= 8'h00;
            ack_q      <= 1'b0;
            rdata_q    <= 8'h00;
            irq_q      <= 1'b0;
            ctrl_q     <= 8'h00;
            mask_q     <= 8'h00;
            pend_q     <= 8'h00;
            shadow_q   <= 8'h00;
            timer_q    <= 16'h0000;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            src_prev_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            ctrl_q     <= ctrl_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            shadow_q   <= shadow_d;
            timer_q    <= timer_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            src_prev_q <= src_prev_d;
        end
    end

    // Scratch storage: contents are undefined after reset, so no reset term.
    always_ff @(posedge clk_clk) begin
        scratch_q <= scratch_d;
    end

endmodule
